deserializer: RTL and testbench
===============================

# deserializer

Serial-to-parallel receive end for the team's single-bit data path. Collects `DATA_W` qualified serial bits from an upstream serializer or registered bit stream, assembles them into a word and presents that word with a one-cycle valid strobe. The block sits between a bit-level link and word-oriented downstream logic; it applies no backpressure.

## Interface
- `DATA_W`, 16, width of the assembled word; legal range 2..64.
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low (0 = reset).
- `data_i`  in  1  serial data bit; sampled only when `data_val_i` = 1.
- `data_val_i`  in  1  qualifies `data_i` on this edge.
- `clear_i`  in  1  synchronous frame abort; discards the partial word.
- `deser_data_o`  out  `DATA_W`  assembled word; valid when `deser_data_val_o` = 1.
- `deser_data_val_o`  out  1  one-cycle strobe: new word on `deser_data_o`.
- `busy_o`  out  1  1 while a partial word holds 1..`DATA_W`-1 bits.

## Operation
- Internal: shift register `sr` (`DATA_W` bits), bit counter `cnt` ($clog2(`DATA_W`+1) bits), output register, valid flag.
- States: IDLE (`cnt` = 0) and COLLECT (`cnt` in 1..`DATA_W`-1). No other encoded FSM.
- Each edge with `data_val_i` = 1 and `clear_i` = 0: shift `data_i` into `sr`; `cnt` increments.
- Bit order (default): MSB first. The first accepted bit lands in `deser_data_o[DATA_W-1]` and the last in bit 0.
- Word completion: the edge that accepts bit number `DATA_W` loads the output register with the full word, including that bit. The same edge sets `deser_data_val_o` = 1 and returns `cnt` to 0 (IDLE).
- `deser_data_val_o` is high for exactly one cycle per word. It is never high on two consecutive cycles unless `DATA_W` valid bits arrive between them, which is impossible for `DATA_W` >= 2.
- `deser_data_o` holds its last word until the next completion. It does not change on partial bits.
- Gaps: `data_val_i` = 0 cycles are ignored. `cnt` and `sr` hold, and there is no timeout.
- `busy_o` = (`cnt` != 0), registered.
- `clear_i` = 1 sets `cnt` to 0 and discards the partial word. `data_i` is ignored that cycle even if `data_val_i` = 1. `deser_data_o` is unchanged, and no strobe is generated that edge.
- `clear_i` has priority over word completion. If `clear_i` coincides with the final bit, no word is produced.
- Reset (`rst_i` = 0, any time, mid-word included) clears immediately, without waiting for a clock edge:
  - `deser_data_o` = 0
  - `deser_data_val_o` = 0
  - `busy_o` = 0
  - `cnt` = 0
  - `sr` = 0
- After `rst_i` deasserts, the first edge with `data_val_i` = 1 is bit 1 of a new word.

## Timing
- Latency: strobe and word appear on the clock edge that samples the `DATA_W`-th valid bit, i.e. visible in the cycle after that bit is presented. No additional pipeline stage.
- Minimum word period: `DATA_W` cycles with `data_val_i` held high. Back-to-back words are supported with no dead cycle. The bit after completion is bit 1 of the next word, accepted on the same edge pattern.
- All outputs are registered; no combinational input-to-output path.
- Reset assertion is asynchronous. Deassertion must be synchronous to `clk_i`; the deassertion synchronizer is the system's responsibility.

## Configuration
- `DESER_LSB_FIRST_EN` defined: first accepted bit lands in `deser_data_o[0]` and the last in `deser_data_o[DATA_W-1]`. Implemented as a right shift.
- Not defined: MSB-first as above.
- All other behaviour, latency and reset values are identical in both builds.

## Test plan
- Reset: `rst_i` = 0 mid-word with 5 bits collected, asserted between edges. Outputs go to 0 before the next edge. After release, 16 bits of 0xA5C3 (MSB first) yield `deser_data_o` = 0xA5C3 and a 1-cycle strobe.
- Streaming: 3 words 0x1234, 0xFFFF, 0x0001 sent with `data_val_i` continuously high. Required response: strobes exactly 16 cycles apart, words in order, `busy_o` low only on completion cycles.
- Gaps: 0xBEEF sent with `data_val_i` randomly deasserted 0..3 cycles between bits. Required response: single strobe with 0xBEEF; `deser_data_o` unchanged until then.
- Abort: `clear_i` pulsed after 7 bits, then 0x8001 sent. Required response: one strobe with 0x8001; no strobe for the aborted fragment.
- Simultaneous abort: `clear_i` = 1 on the edge carrying the 16th bit. Required response: no strobe, `busy_o` = 0, `deser_data_o` keeps its previous value.
- LSB-first build (`DESER_LSB_FIRST_EN`): bit stream 1,0,0,0,…,0. Required response: `deser_data_o` = 0x0001. The same stream in the default build gives 0x8000.

Source files
------------

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
//
// Serial-to-parallel receive end for a single-bit data path. Collects DATA_W
// qualified serial bits, assembles them into a word and presents the word with
// a one-cycle valid strobe. No backpressure is applied upstream.
//
// Parameters:
//   DATA_W            assembled word width (2..64)
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             asynchronous reset, active-low
//   data_i            serial data bit, sampled when data_val_i = 1
//   data_val_i        qualifies data_i on this edge
//   clear_i           synchronous frame abort, discards the partial word
//   deser_data_o      assembled word, holds until the next completion
//   deser_data_val_o  one-cycle strobe: new word on deser_data_o
//   busy_o            1 while a partial word holds 1..DATA_W-1 bits
//
// Build option:
//   DESER_LSB_FIRST_EN  defined: first accepted bit lands in bit 0 (right
//                       shift). Undefined: first bit lands in bit DATA_W-1.
// -----------------------------------------------------------------------------
module deserializer #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic              deser_data_val_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  sr;
    logic [DATA_W-1:0]  sr_shift;
    logic               accept;
    logic               last_bit;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear_i outranks both bit acceptance and completion
    always_comb begin
        accept     = data_val_i && !clear_i;
        last_bit   = accept && (cnt == CNT_W'(DATA_W - 1));
        state_next = state;
        if (clear_i) begin
            state_next = IDLE;
        end else if (accept) begin
            state_next = last_bit ? IDLE : COLLECT;
        end
    end

    // Output / shift-path logic
    always_comb begin
        busy_o = (state == COLLECT);
`ifdef DESER_LSB_FIRST_EN
        sr_shift = {data_i, sr[DATA_W-1:1]};
`else
        sr_shift = {sr[DATA_W-2:0], data_i};
`endif
    end

    // Datapath: shift register, bit counter, output word and strobe.
    // The completing edge loads the output from sr_shift so the final bit is
    // included without an extra pipeline stage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sr               <= '0;
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            deser_data_val_o <= 1'b0;
            if (clear_i) begin
                sr  <= '0;
                cnt <= '0;
            end else if (accept) begin
                sr <= sr_shift;
                if (last_bit) begin
                    cnt              <= '0;
                    deser_data_o     <= sr_shift;
                    deser_data_val_o <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// -----------------------------------------------------------------------------
// tb_deserializer
//
// Self-checking bench for deserializer (DATA_W = 16). Expected words are
// queued when a word's stimulus is driven and popped when the DUT strobes.
// A bit-count model predicts strobe and busy timing every cycle.
// Honours DESER_LSB_FIRST_EN for bit ordering.
// -----------------------------------------------------------------------------
module tb_deserializer;

    localparam int unsigned W = 16;

    logic          clk_i;
    logic          rst_i;
    logic          data_i;
    logic          data_val_i;
    logic          clear_i;
    logic [W-1:0]  deser_data_o;
    logic          deser_data_val_o;
    logic          busy_o;

    deserializer #(.DATA_W(W)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .clear_i          (clear_i),
        .deser_data_o     (deser_data_o),
        .deser_data_val_o (deser_data_val_o),
        .busy_o           (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int            checks   = 0;
    int            failures = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  last_word;
    int            mcnt;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit i (0 = first sent) of word w in the build's transmit order
    function automatic logic bit_at(input logic [W-1:0] w, input int i);
`ifdef DESER_LSB_FIRST_EN
        return w[i];
`else
        return w[W-1-i];
`endif
    endfunction

    // One clock cycle: drive on negedge, update model at posedge, check #1 later
    task automatic cycle(input logic dv, input logic d, input logic clr);
        logic         exp_val;
        logic [W-1:0] w;
        @(negedge clk_i);
        data_val_i = dv;
        data_i     = d;
        clear_i    = clr;
        @(posedge clk_i);
        exp_val = 1'b0;
        if (clr) begin
            mcnt = 0;
        end else if (dv) begin
            if (mcnt == W - 1) begin
                mcnt    = 0;
                exp_val = 1'b1;
            end else begin
                mcnt++;
            end
        end
        #1;
        check_eq("strobe", 64'(deser_data_val_o), 64'(exp_val));
        if (deser_data_val_o) begin
            w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check_eq("word", 64'(deser_data_o), 64'(w));
            last_word = w;
        end else begin
            check_eq("hold", 64'(deser_data_o), 64'(last_word));
        end
        check_eq("busy", 64'(busy_o), 64'(mcnt != 0));
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, bit_at(w, i), 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        exp_q.push_back(w);
        send_bits(w, W);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] gw;
        rst_i      = 1'b0;
        data_i     = 1'b0;
        data_val_i = 1'b0;
        clear_i    = 1'b0;
        mcnt       = 0;
        last_word  = '0;
        #23;
        check_eq("rst_data", 64'(deser_data_o), 64'h0);
        check_eq("rst_val", 64'(deser_data_val_o), 64'h0);
        check_eq("rst_busy", 64'(busy_o), 64'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        idle(2);

        // Streaming: back-to-back words, no dead cycles
        send_word(16'h1234);
        send_word(16'hFFFF);
        send_word(16'h0001);
        idle(2);

        // Gaps between bits
        gw = 16'hBEEF;
        exp_q.push_back(gw);
        for (int i = 0; i < int'(W); i++) begin
            cycle(1'b1, bit_at(gw, i), 1'b0);
            idle(int'($urandom_range(0, 3)));
        end
        idle(2);

        // Abort after 7 bits, then a full word
        send_bits(16'h7F3C, 7);
        cycle(1'b0, 1'b0, 1'b1);
        send_word(16'h8001);
        idle(1);

        // Abort with data_val_i high mid-word
        send_bits(16'h5555, 4);
        cycle(1'b1, 1'b1, 1'b1);
        send_word(16'h00FF);

        // Clear coincides with the 16th bit: no word produced
        send_bits(16'hC0DE, W - 1);
        cycle(1'b1, bit_at(16'hC0DE, W - 1), 1'b1);
        idle(2);

        // Single leading one: position shows the build's bit order
`ifdef DESER_LSB_FIRST_EN
        exp_q.push_back(16'h0001);
`else
        exp_q.push_back(16'h8000);
`endif
        for (int i = 0; i < int'(W); i++) cycle(1'b1, (i == 0), 1'b0);
        idle(1);

        // Asynchronous reset mid-word (5 bits collected), between edges
        send_bits(16'h3C3C, 5);
        #2;
        rst_i = 1'b0;
        #1;
        check_eq("arst_data", 64'(deser_data_o), 64'h0);
        check_eq("arst_val", 64'(deser_data_val_o), 64'h0);
        check_eq("arst_busy", 64'(busy_o), 64'h0);
        mcnt      = 0;
        last_word = '0;
        exp_q.delete();
        @(negedge clk_i);
        rst_i = 1'b1;
        data_val_i = 1'b0;
        idle(1);
        send_word(16'hA5C3);
        idle(2);

        check_eq("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
